btn_event_gen: RTL and testbench

Front end for the board push-button. Turns raw, bouncing, asynchronous BTN_N into clean, single-cycle, CLK-domain event pulses: press, release and auto-repeat, plus a debounced level. Consumers such as digit counters and display drivers use STEP instead of doing their own edge detection.

---
 rtl/btn_event_gen.sv | 154 +++++++++++++++
 tb/tb_btn_event_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_gen.sv
// ============================================================================
// Module   : btn_event_gen
// Purpose  : Debounces the raw active-low push-button and emits one-cycle
//            press / release / auto-repeat pulses plus a clean held level.
// Options  : BTN_AUTOREPEAT_EN enables the REPEAT state and REPEAT_PULSE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event_gen #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_RATE     = 1200000,
  parameter int CNT_W           = 24
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_N,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic REPEAT_PULSE,
  output logic STEP
);

  localparam longint c_CNT_LIMIT = longint'(1) << CNT_W;

  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > c_CNT_LIMIT ||
      REPEAT_DELAY < 1 || longint'(REPEAT_DELAY) > c_CNT_LIMIT ||
      REPEAT_RATE < 1 || longint'(REPEAT_RATE) > c_CNT_LIMIT) begin : g_param_check
    $error("btn_event_gen: count parameter out of range");
  end

  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] c_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HOLD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_timer;

  // Two-flop synchronizer; reset to the released level so reset exit is quiet.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= BTN_N;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      PRESSED       <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      REPEAT_PULSE  <= 1'b0;
      STEP          <= 1'b0;
    end else begin
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      REPEAT_PULSE  <= 1'b0;
      STEP          <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (!r_s2) r_state <= DB_PRESS;
        end
        DB_PRESS: begin
          if (r_s2) begin
            r_state <= IDLE;
            r_timer <= '0;
          end else if (r_timer == c_DB_LAST) begin
            r_state     <= HOLD;
            r_timer     <= '0;
            PRESSED     <= 1'b1;
            PRESS_PULSE <= 1'b1;
            STEP        <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        HOLD: begin
          if (r_s2) begin
            r_state <= DB_RELEASE;
            r_timer <= '0;
`ifdef BTN_AUTOREPEAT_EN
          end else if (r_timer == c_DELAY_LAST) begin
            r_state      <= REPEAT;
            r_timer      <= '0;
            REPEAT_PULSE <= 1'b1;
            STEP         <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
`else
          end
          // Without auto-repeat the timer is parked at zero so it cannot wrap.
`endif
        end
`ifdef BTN_AUTOREPEAT_EN
        REPEAT: begin
          if (r_s2) begin
            r_state <= DB_RELEASE;
            r_timer <= '0;
          end else if (r_timer == c_RATE_LAST) begin
            r_timer      <= '0;
            REPEAT_PULSE <= 1'b1;
            STEP         <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif
        DB_RELEASE: begin
          // A re-press during release debounce restarts repeat timing silently.
          if (!r_s2) begin
            r_state <= HOLD;
            r_timer <= '0;
          end else if (r_timer == c_DB_LAST) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            PRESSED       <= 1'b0;
            RELEASE_PULSE <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
          PRESSED <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_event_gen.sv
// ============================================================================
// Module   : tb_btn_event_gen
// Purpose  : Directed plus randomized bench for btn_event_gen against an
//            event-level reference model (run-length debounce, repeat cadence).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_event_gen;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BTN_N = 1'b1;
  logic PRESSED, PRESS_PULSE, RELEASE_PULSE, REPEAT_PULSE, STEP;

  btn_event_gen #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_N(BTN_N), .PRESSED(PRESSED),
    .PRESS_PULSE(PRESS_PULSE), .RELEASE_PULSE(RELEASE_PULSE),
    .REPEAT_PULSE(REPEAT_PULSE), .STEP(STEP)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: BTN_N seen by the decision logic two edges late; a level
  // is accepted after D+1 consecutive samples disagreeing with the current one.
  logic hist[$];
  logic acc;
  int   run, anchor, edge_n;
  logic e_press, e_rel, e_rep, e_pressed;

  // Observation counters for the directed scenarios.
  int n_press, n_rel, n_rep, n_step, rel_cyc, press_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = '{1'b1, 1'b1};
    acc = 1'b1; run = 0; anchor = 0;
    e_press = 0; e_rel = 0; e_rep = 0; e_pressed = 0;
  endtask

  task automatic model_edge();
    logic s;
    int t;
    edge_n++;
    s = hist.pop_front();
    hist.push_back(BTN_N);
    e_press = 0; e_rel = 0; e_rep = 0;
    if (s != acc) begin
      run++;
      if (run == D + 1) begin
        acc = s; run = 0;
        if (s == 1'b0) begin e_press = 1; anchor = edge_n; end
        else e_rel = 1;
      end
    end else begin
      if (run > 0 && acc == 1'b0) anchor = edge_n;
      run = 0;
      if (acc == 1'b0 && AR) begin
        t = edge_n - anchor;
        if (t >= RD && (t - RD) % RR == 0) e_rep = 1;
      end
    end
    e_pressed = (acc == 1'b0);
  endtask

  task automatic compare_all();
    chk("press", PRESS_PULSE, e_press);
    chk("release", RELEASE_PULSE, e_rel);
    chk("repeat", REPEAT_PULSE, e_rep);
    chk("step", STEP, e_press | e_rep);
    chk("pressed", PRESSED, e_pressed);
    chk("mutex", $onehot0({PRESS_PULSE, RELEASE_PULSE, REPEAT_PULSE}), 1);
    if (PRESS_PULSE) begin n_press++; press_at = rel_cyc; end
    n_rel  += RELEASE_PULSE;
    n_rep  += REPEAT_PULSE;
    n_step += STEP;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset(); else model_edge();
    @(negedge CLK);
    compare_all();
    rel_cyc++;
  endtask

  task automatic run_level(input logic lvl, input int n);
    BTN_N = lvl;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_rep = 0; n_step = 0; rel_cyc = 0; press_at = -1;
  endtask

  task automatic async_reset(input int n);
    #2 RST = 1'b1;
    #1;
    chk("rst_pressed", PRESSED, 0);
    chk("rst_press", PRESS_PULSE, 0);
    chk("rst_release", RELEASE_PULSE, 0);
    chk("rst_repeat", REPEAT_PULSE, 0);
    chk("rst_step", STEP, 0);
    model_reset();
    repeat (n) tick();
    RST = 1'b0;
  endtask

  initial begin
    model_reset();
    edge_n = 0;
    clear_counts();
    #1;
    chk("init_pressed", PRESSED, 0);
    chk("init_step", STEP, 0);
    repeat (3) tick();
    RST = 1'b0;
    run_level(1'b1, 5);

    // Clean press held long enough for the full repeat train, then release.
    clear_counts();
    run_level(1'b0, 47);
    chk("press_latency", press_at, D + 2);
    run_level(1'b1, 10);
    chk("hold_repeats", n_rep, AR ? 11 : 0);
    chk("hold_steps", n_step, AR ? 12 : 1);
    chk("hold_releases", n_rel, 1);

    // Short glitch: no events at all.
    clear_counts();
    run_level(1'b0, 3);
    run_level(1'b1, 12);
    chk("glitch_events", n_press + n_rel + n_step, 0);

    // Release bounce: one release only, no second press.
    run_level(1'b0, 8);
    clear_counts();
    run_level(1'b1, 3);
    run_level(1'b0, 2);
    run_level(1'b1, 12);
    chk("bounce_releases", n_rel, 1);
    chk("bounce_presses", n_press, 0);

    // Reset while auto-repeating, then quiet reset exit.
    run_level(1'b0, 25);
    BTN_N = 1'b1;
    async_reset(2);
    clear_counts();
    run_level(1'b1, 50);
    chk("post_reset_events", n_press + n_rel + n_rep + n_step, 0);

    // Reset in the middle of press debounce restarts the debounce.
    run_level(1'b0, 4);
    async_reset(1);
    clear_counts();
    run_level(1'b0, 10);
    chk("mid_db_latency", press_at, D + 2);
    run_level(1'b1, 10);

    // Randomized bounce/hold segments.
    for (int i = 0; i < 250; i++) begin
      int len;
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
      run_level(1'(i % 2 == 0 ? 0 : 1), len);
    end
    run_level(1'b1, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
